// File: rtl/execute_upwards_mix_array_reader.sv
// execute_upwards_mix_array_reader: streams len words from the mix_array read port onto a valid/ready stream.
// Define MIX_READER_SUM_EN to add the running-sum output of handshaken words.
module execute_upwards_mix_array_reader #(
   parameter int DataWidth    = 32,
   parameter int AddressRange = 33,
   parameter int AddressWidth = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [AddressWidth-1:0] base,
   input  logic [AddressWidth-1:0] len,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [AddressWidth-1:0] address1,
   output logic                    ce1,
   input  logic [DataWidth-1:0]    q1,
   output logic [DataWidth-1:0]    m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    m_last,
`ifdef MIX_READER_SUM_EN
   output logic [DataWidth+AddressWidth-1:0] sum,
`endif
   output logic [1:0]              fsm_state
);

   // Stream handshake: a beat transfers on a rising edge where m_valid && m_ready; m_valid never
   // depends on m_ready, and m_data/m_last hold while m_valid && !m_ready.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [AddressWidth-1:0] RANGE     = AddressWidth'(AddressRange);
   localparam logic [AddressWidth-1:0] LAST_ADDR = AddressWidth'(AddressRange - 1);
   localparam logic [AddressWidth-1:0] ONE       = AddressWidth'(1);

   logic [1:0]              state;
   logic [AddressWidth-1:0] ptr;
   logic [AddressWidth-1:0] len_q;
   logic [AddressWidth-1:0] issued;
   logic                    inflight;
   logic                    inflight_last;
   logic [1:0]              count;
   logic [DataWidth-1:0]    head_data;
   logic [DataWidth-1:0]    tail_data;
   logic                    head_last;
   logic                    tail_last;
   logic                    err_q;
   logic                    cmd_bad;
   logic                    accept;
   logic                    pop;
   logic                    push;
   logic                    last_issue;
   logic [2:0]              occ;

   assign cmd_bad    = (base >= RANGE) || (len > RANGE);
   assign accept     = (state == S_IDLE) && start && !cmd_bad;
   assign m_valid    = (count != 2'd0);
   assign pop        = m_valid && m_ready;
   assign push       = inflight;
   assign occ        = {1'b0, count} + {2'b00, inflight};
   // A slot freed by this cycle's pop is reusable, so back-to-back reads sustain one word per cycle.
   assign ce1        = (state == S_RUN) && (issued != len_q) &&
                       ((occ < 3'd2) || ((occ == 3'd2) && pop));
   assign last_issue = ce1 && (issued == len_q - ONE);

   assign address1  = ptr;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign err       = err_q;
   assign m_data    = head_data;
   assign m_last    = m_valid && head_last;
   assign fsm_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         len_q <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (cmd_bad) begin
                     err_q <= 1'b1;
                  end else if (len == '0) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_RUN;
                     len_q <= len;
                  end
               end
            end
            S_RUN:   if (last_issue) state <= S_DRAIN;
            S_DRAIN: if (pop && head_last && !inflight) state <= S_DONE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr           <= '0;
         issued        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= ce1;
         inflight_last <= last_issue;
         if (accept) begin
            ptr    <= base;
            issued <= '0;
         end else if (ce1) begin
            ptr    <= (ptr == LAST_ADDR) ? '0 : ptr + ONE;
            issued <= issued + ONE;
         end
      end
   end

   // Two-entry FIFO; head register drives the stream directly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= 2'd0;
         head_data <= '0;
         tail_data <= '0;
         head_last <= 1'b0;
         tail_last <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head_data <= q1;
                  head_last <= inflight_last;
               end else begin
                  tail_data <= q1;
                  tail_last <= inflight_last;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               head_data <= tail_data;
               head_last <= tail_last;
               count     <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head_data <= q1;
                  head_last <= inflight_last;
               end else begin
                  head_data <= tail_data;
                  head_last <= tail_last;
                  tail_data <= q1;
                  tail_last <= inflight_last;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MIX_READER_SUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum <= '0;
      end else if (accept) begin
         sum <= '0;
      end else if (pop) begin
         sum <= sum + {{AddressWidth{1'b0}}, m_data};
      end
   end
`endif

endmodule

// File: tb/tb_execute_upwards_mix_array_reader.sv
// Directed bench for execute_upwards_mix_array_reader: vector table plus hand-written corner sequences.
module tb_execute_upwards_mix_array_reader;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int AR = 33;

   typedef struct {
      logic [AW-1:0] base;
      logic [AW-1:0] len;
      int            mode;
      bit            exp_err;
      logic [DW-1:0] exp_first;
      logic [DW-1:0] exp_final;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base;
   logic [AW-1:0] len;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW-1:0] address1;
   logic          ce1;
   logic [DW-1:0] q1;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;
   logic [1:0]    fsm_state;
`ifdef MIX_READER_SUM_EN
   logic [DW+AW-1:0] sum;
   logic [DW+AW-1:0] sum_at_done;
`endif

   execute_upwards_mix_array_reader #(
      .DataWidth(DW), .AddressRange(AR), .AddressWidth(AW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .base(base), .len(len),
      .busy(busy), .done(done), .err(err), .address1(address1), .ce1(ce1), .q1(q1),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
`ifdef MIX_READER_SUM_EN
      .sum(sum),
`endif
      .fsm_state(fsm_state)
   );

   // clock / reset, RAM model
   logic [DW-1:0] ram [64];
   int cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (ce1) q1 <= ram[address1];

   // scoreboard state
   int n_checks = 0;
   int n_fail = 0;
   logic [DW-1:0] exp_q[$];
   int ready_mode = 0;
   int out_cnt = 0;
   int done_cnt, err_cnt, last_cnt, beats_total = 0;
   int done_cyc, err_cyc, last_cyc, first_valid_cyc;
   logic [DW-1:0] first_data, last_data;
   bit prev_stall = 1'b0;
   logic [DW+1:0] prev_head;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = cyc[0];
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // monitor: samples on the falling edge
   always @(negedge clk) begin
      if (!reset) begin
         out_cnt    = 0;
         prev_stall = 1'b0;
      end else begin
         logic [DW-1:0] e;
         int p;
         p = (m_valid && m_ready) ? 1 : 0;
         if (prev_stall) check("stall_hold", 64'({m_valid, m_last, m_data}), 64'(prev_head));
         if (ce1) check("credit", 64'((out_cnt - p) < 2), 64'(1));
         out_cnt = out_cnt + (ce1 ? 1 : 0) - p;
         if (m_valid && first_valid_cyc < 0) begin
            first_valid_cyc = cyc;
            first_data      = m_data;
         end
         if (p == 1) begin
            beats_total++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL extra_beat: got 0x%0h, expected no beat (cycle %0d)", m_data, cyc);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", 64'(m_data), 64'(e));
               check("beat_last", 64'(m_last), 64'(exp_q.size() == 0));
            end
            if (m_last) begin
               last_cnt++;
               last_cyc  = cyc;
               last_data = m_data;
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
`ifdef MIX_READER_SUM_EN
            sum_at_done = sum;
`endif
         end
         if (err) begin
            err_cnt++;
            err_cyc = cyc;
            check("err_busy", 64'(busy), 64'(0));
         end
         prev_stall = m_valid && !m_ready;
         prev_head  = {m_valid, m_last, m_data};
      end
   end

   // driver tasks
   task automatic clear_marks();
      done_cnt = 0; err_cnt = 0; last_cnt = 0;
      done_cyc = -1; err_cyc = -1; last_cyc = -1; first_valid_cyc = -1;
   endtask

   task automatic fill_exp(input logic [AW-1:0] b, input logic [AW-1:0] l);
      for (int i = 0; i < int'(l); i++) exp_q.push_back(DW'((int'(b) + i) % AR + 100));
   endtask

   task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] l, output int sc);
      @(posedge clk); #1;
      start = 1'b1; base = b; len = l; sc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_end(input string name);
      int n;
      n = 0;
      while (done_cnt == 0 && err_cnt == 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      if (n >= 400) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got no done/err, expected one within 400 cycles", name);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int sc;
      ready_mode = v.mode;
      clear_marks();
      if (!v.exp_err) fill_exp(v.base, v.len);
      pulse_start(v.base, v.len, sc);
      check("busy_after_start", 64'(busy), 64'(!v.exp_err));
      wait_end("vec");
      repeat (4) @(posedge clk);
      check("err_count", 64'(err_cnt), 64'(v.exp_err));
      check("done_count", 64'(done_cnt), 64'(!v.exp_err));
      check("leftover_words", 64'(exp_q.size()), 64'(0));
      check("last_count", 64'(last_cnt), 64'(!v.exp_err && v.len != 0));
      if (v.exp_err) begin
         check("err_timing", 64'(err_cyc - sc), 64'(1));
      end else if (v.len == 0) begin
         check("done_timing_len0", 64'(done_cyc - sc), 64'(1));
         check("no_valid_len0", 64'(first_valid_cyc), 64'(-1));
      end else begin
         check("first_latency", 64'(first_valid_cyc - sc), 64'(3));
         check("first_word", 64'(first_data), 64'(v.exp_first));
         check("final_word", 64'(last_data), 64'(v.exp_final));
         check("done_after_last", 64'(done_cyc - last_cyc), 64'(1));
      end
      check("idle_after", 64'(busy), 64'(0));
      exp_q.delete();
   endtask

   vec_t vecs[8];

   initial begin
      int sc;
      int n;
      vec_t v;
      vecs[0] = '{base: 6'd0,  len: 6'd4,  mode: 0, exp_err: 1'b0, exp_first: 32'd100, exp_final: 32'd103};
      vecs[1] = '{base: 6'd30, len: 6'd5,  mode: 0, exp_err: 1'b0, exp_first: 32'd130, exp_final: 32'd101};
      vecs[2] = '{base: 6'd0,  len: 6'd33, mode: 1, exp_err: 1'b0, exp_first: 32'd100, exp_final: 32'd132};
      vecs[3] = '{base: 6'd0,  len: 6'd0,  mode: 0, exp_err: 1'b0, exp_first: 32'd0,   exp_final: 32'd0};
      vecs[4] = '{base: 6'd33, len: 6'd1,  mode: 0, exp_err: 1'b1, exp_first: 32'd0,   exp_final: 32'd0};
      vecs[5] = '{base: 6'd0,  len: 6'd34, mode: 0, exp_err: 1'b1, exp_first: 32'd0,   exp_final: 32'd0};
      vecs[6] = '{base: 6'd32, len: 6'd1,  mode: 2, exp_err: 1'b0, exp_first: 32'd132, exp_final: 32'd132};
      vecs[7] = '{base: 6'd10, len: 6'd33, mode: 2, exp_err: 1'b0, exp_first: 32'd110, exp_final: 32'd109};

      for (int i = 0; i < 64; i++) ram[i] = DW'(i + 100);
      reset = 1'b0; start = 1'b0; base = '0; len = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_ce1", 64'(ce1), 64'(0));
      check("rst_address1", 64'(address1), 64'(0));
      check("rst_m_valid", 64'(m_valid), 64'(0));
      check("rst_m_last", 64'(m_last), 64'(0));
      check("rst_m_data", 64'(m_data), 64'(0));
      check("rst_state", 64'(fsm_state), 64'(0));
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // start while running must be ignored, not queued
      ready_mode = 0;
      clear_marks();
      fill_exp(6'd0, 6'd10);
      pulse_start(6'd0, 6'd10, sc);
      repeat (3) @(posedge clk);
      #1; start = 1'b1; base = 6'd20; len = 6'd3;
      @(posedge clk); #1; start = 1'b0;
      wait_end("ignore");
      repeat (12) @(posedge clk);
      check("ignore_done_count", 64'(done_cnt), 64'(1));
      check("ignore_err_count", 64'(err_cnt), 64'(0));
      check("ignore_last_count", 64'(last_cnt), 64'(1));
      check("ignore_leftover", 64'(exp_q.size()), 64'(0));
      exp_q.delete();

      // reset in the middle of a 10-word command, after 5 words
      clear_marks();
      fill_exp(6'd0, 6'd10);
      n = beats_total;
      pulse_start(6'd0, 6'd10, sc);
      while (beats_total < n + 5 && cyc < sc + 100) @(posedge clk);
      check("mid_beats_reached", 64'(beats_total - n), 64'(5));
      #2; reset = 1'b0;
      #1;
      check("abort_m_valid", 64'(m_valid), 64'(0));
      check("abort_ce1", 64'(ce1), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_m_last", 64'(m_last), 64'(0));
      check("abort_state", 64'(fsm_state), 64'(0));
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      check("abort_no_done", 64'(done_cnt), 64'(0));
      v = '{base: 6'd3, len: 6'd4, mode: 0, exp_err: 1'b0, exp_first: 32'd103, exp_final: 32'd106};
      run_vec(v);

`ifdef MIX_READER_SUM_EN
      v = '{base: 6'd0, len: 6'd4, mode: 1, exp_err: 1'b0, exp_first: 32'd100, exp_final: 32'd103};
      run_vec(v);
      check("sum_at_done", 64'(sum_at_done), 64'(406));
      check("sum_hold", 64'(sum), 64'(406));
      clear_marks();
      ready_mode = 0;
      fill_exp(6'd5, 6'd2);
      pulse_start(6'd5, 6'd2, sc);
      check("sum_cleared", 64'(sum), 64'(0));
      wait_end("sum");
      repeat (3) @(posedge clk);
      check("sum_second", 64'(sum), 64'(211));
      exp_q.delete();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
